// File: rtl/store_write_responder.sv
// Memory-side responder for the store buffer drain port: fixed write latency, single-cycle ack, registered read port.
// Optional store-to-load forwarding is compiled in with STORE_RESP_FWD_EN.

// state   | meaning
// IDLE    | waiting for mem_valid; latches the store on the accepting edge
// BUSY    | write latency timer running; commit (or drop) at terminal count
// ACK     | mem_ready (and wr_err if dropped) asserted for this one cycle
// RECOVER | swallows the requester's stale valid left over from the ack cycle
module store_write_responder #(
  parameter int DEPTH         = 256,
  parameter int WRITE_LATENCY = 3,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_valid,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_data,
  output logic                 mem_ready,
  input  logic [31:0]          rd_addr,
  output logic [31:0]          rd_data,
  output logic                 busy,
  output logic                 wr_err,
  output logic [CNT_WIDTH-1:0] write_count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAT_W = $clog2(WRITE_LATENCY + 1);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    ACK     = 2'd2,
    RECOVER = 2'd3
  } state_t;

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic [IDX_W-1:0]   lat_idx;
  logic [31:0]        lat_data;
  logic               lat_err;

  logic [31:0]        mem [DEPTH];

  logic [IDX_W-1:0]   mem_idx;
  logic [IDX_W-1:0]   rd_idx;
  logic               mem_err;
  logic               term_cnt;
  logic               commit;
  logic               fwd_hit;
  logic               unused_rd_bits;

  assign mem_idx  = mem_addr[IDX_W+1:2];
  assign rd_idx   = rd_addr[IDX_W+1:2];
  assign mem_err  = (mem_addr[1:0] != 2'b00) || ({1'b0, mem_addr} >= ADDR_LIMIT);
  assign term_cnt = (lat_cnt == LAT_W'(1));
  assign commit   = (state == BUSY) && term_cnt && !lat_err;

  // Read port only looks at the word index; upper and byte bits wrap away.
  assign unused_rd_bits = ^{rd_addr[31:IDX_W+2], rd_addr[1:0]};

`ifdef STORE_RESP_FWD_EN
  assign fwd_hit = (state == BUSY) && (rd_idx == lat_idx) && !lat_err;
`else
  assign fwd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      lat_idx     <= '0;
      lat_data    <= '0;
      lat_err     <= 1'b0;
      mem_ready   <= 1'b0;
      busy        <= 1'b0;
      wr_err      <= 1'b0;
      write_count <= '0;
    end else begin
      mem_ready <= 1'b0;
      wr_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_valid) begin
            lat_idx  <= mem_idx;
            lat_data <= mem_data;
            lat_err  <= mem_err;
            lat_cnt  <= LAT_W'(WRITE_LATENCY);
            busy     <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          lat_cnt <= lat_cnt - LAT_W'(1);
          if (term_cnt) begin
            if (!lat_err) begin
              write_count <= write_count + CNT_WIDTH'(1);
            end
            mem_ready <= 1'b1;
            wr_err    <= lat_err;
            state     <= ACK;
          end
        end
        ACK: begin
          state <= RECOVER;
        end
        RECOVER: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Array has no reset so it can map onto a plain RAM.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[lat_idx] <= lat_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (fwd_hit) begin
      rd_data <= lat_data;
    end else begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_store_write_responder.sv
// Directed bench for store_write_responder: latency, back-to-back, drops, reset abort, same-edge read, count wrap.
module tb_store_write_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic [31:0] rd_addr = '0;
  logic        mem_ready;
  logic [31:0] rd_data;
  logic        busy;
  logic        wr_err;
  logic [15:0] write_count;

  logic        unused_w_ready;
  logic [31:0] unused_w_rd;
  logic        unused_w_busy;
  logic        unused_w_err;
  logic [1:0]  w_count;

  int n_chk = 0;
  int n_err = 0;
  int exp_wc = 0;

  always #5 clk = ~clk;

  store_write_responder u_dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .wr_err(wr_err), .write_count(write_count)
  );

  store_write_responder #(.CNT_WIDTH(2)) u_wrap (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(unused_w_ready), .rd_addr(rd_addr),
    .rd_data(unused_w_rd), .busy(unused_w_busy), .wr_err(unused_w_err),
    .write_count(w_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester model: hold valid until ack, keep stale valid one more cycle, then drop.
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic exp_err);
    logic seen = 1'b0;
    logic err_at_ack = 1'b0;
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_data  = d;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_ready) begin
        seen = 1'b1;
        err_at_ack = wr_err;
        break;
      end
    end
    chk("ack_seen", 32'(seen), 32'd1);
    chk("wr_err_at_ack", 32'(err_at_ack), 32'(exp_err));
    tick();
    mem_valid = 1'b0;
    tick();
    if (!exp_err) exp_wc++;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rd_addr = a;
    tick();
    chk(tag, rd_data, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    exp_wc = 0;
  endtask

  initial begin
    int pulses;
    int cyc[4];
    int idx;
    logic stale;
    logic [31:0] seq_addr[2];
    logic [31:0] seq_data[2];
    logic [1:0]  wrap_exp[5];

    // Reset state
    #2;
    chk("rst_ready", 32'(mem_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(wr_err), 32'd0);
    chk("rst_rd", rd_data, 32'd0);
    chk("rst_wc", 32'(write_count), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Single store: busy from cycle 1 to 5, ready only in cycle 4
    mem_valid = 1'b1;
    mem_addr  = 32'h10;
    mem_data  = 32'hDEADBEEF;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk($sformatf("s1_busy_c%0d", c), 32'(busy), 32'(c <= 5));
      chk($sformatf("s1_ready_c%0d", c), 32'(mem_ready), 32'(c == 4));
      if (c == 5) mem_valid = 1'b0;
    end
    exp_wc++;
    rd_chk("s1_read", 32'h10, 32'hDEADBEEF);
    chk("s1_wc", 32'(write_count), 32'(exp_wc));

    // Back-to-back with stale valid after each transfer
    seq_addr[0] = 32'h0; seq_data[0] = 32'h11111111;
    seq_addr[1] = 32'h4; seq_data[1] = 32'h22222222;
    pulses = 0;
    idx = 0;
    stale = 1'b0;
    mem_valid = 1'b1;
    mem_addr  = seq_addr[0];
    mem_data  = seq_data[0];
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (mem_ready) begin
        if (pulses < 4) cyc[pulses] = c;
        pulses++;
      end
      if (stale) begin
        stale = 1'b0;
        idx++;
        if (idx < 2) begin
          mem_addr = seq_addr[idx];
          mem_data = seq_data[idx];
        end else begin
          mem_valid = 1'b0;
        end
      end
      if (mem_ready) stale = 1'b1;
    end
    exp_wc += 2;
    chk("b2b_pulses", 32'(pulses), 32'd2);
    if (pulses >= 2) chk("b2b_spacing", 32'(cyc[1] - cyc[0]), 32'd6);
    chk("b2b_wc", 32'(write_count), 32'(exp_wc));
    rd_chk("b2b_rd0", 32'h0, 32'h11111111);
    rd_chk("b2b_rd4", 32'h4, 32'h22222222);

    // Dropped stores: both alias word index 0
    store(32'h402, 32'hBAD00001, 1'b1);
    chk("mis_wc", 32'(write_count), 32'(exp_wc));
    rd_chk("mis_rd", 32'h0, 32'h11111111);
    store(32'h400, 32'hBAD00002, 1'b1);
    chk("oor_wc", 32'(write_count), 32'(exp_wc));
    rd_chk("oor_rd", 32'h0, 32'h11111111);
    rd_chk("wrap_rd_idx", 32'h404, 32'h22222222);

    // Reset in the 2nd BUSY cycle
    store(32'h20, 32'h12345678, 1'b0);
    mem_valid = 1'b1;
    mem_addr  = 32'h20;
    mem_data  = 32'hCAFEF00D;
    rd_addr   = 32'h20;
    tick();
    tick();
    chk("ab_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("ab_ready", 32'(mem_ready), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_err", 32'(wr_err), 32'd0);
    chk("ab_rd", rd_data, 32'd0);
    chk("ab_wc", 32'(write_count), 32'd0);
    exp_wc = 0;
    pulses = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (mem_ready) pulses++;
    end
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (mem_ready) pulses++;
    end
    chk("ab_no_ack", 32'(pulses), 32'd0);
    rd_chk("ab_kept", 32'h20, 32'h12345678);
    store(32'h20, 32'hCAFEF00D, 1'b0);
    rd_chk("ab_fresh", 32'h20, 32'hCAFEF00D);
    chk("ab_fresh_wc", 32'(write_count), 32'(exp_wc));

    // Same-edge read at commit
    store(32'h8, 32'h0, 1'b0);
    rd_addr   = 32'h8;
    mem_valid = 1'b1;
    mem_addr  = 32'h8;
    mem_data  = 32'h5A5A5A5A;
    tick();
    tick();
`ifdef STORE_RESP_FWD_EN
    chk("se_busy_rd", rd_data, 32'h5A5A5A5A);
`else
    chk("se_busy_rd", rd_data, 32'h0);
`endif
    tick();
    tick();
    chk("se_ready", 32'(mem_ready), 32'd1);
`ifdef STORE_RESP_FWD_EN
    chk("se_same_edge", rd_data, 32'h5A5A5A5A);
`else
    chk("se_same_edge", rd_data, 32'h0);
`endif
    tick();
    mem_valid = 1'b0;
    chk("se_after", rd_data, 32'h5A5A5A5A);
    tick();
    exp_wc++;
    chk("se_wc", 32'(write_count), 32'(exp_wc));

    // write_count wrap on the CNT_WIDTH=2 instance
    do_reset();
    tick();
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;
    for (int k = 0; k < 5; k++) begin
      store(32'h40 + 32'(4 * k), 32'hA0000000 + 32'(k), 1'b0);
      chk($sformatf("wrap_%0d", k), 32'(w_count), 32'(wrap_exp[k]));
    end
    chk("wrap_wide_wc", 32'(write_count), 32'(exp_wc));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
